// File: rtl/soc_rst_seq_pkg.sv
// Shared definitions for the clock/reset sequencer: state encodings and the
// lock-failure counter ceiling.
package soc_rst_seq_pkg;

  localparam logic [1:0] ST_PLL_RST   = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_SOC_HOLD  = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  localparam logic [3:0] FAIL_CNT_MAX = 4'd15;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == FAIL_CNT_MAX) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/soc_rst_seq_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; resets to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/soc_rst_seq.sv
// Ref-clock reset sequencer: pulses PLL reset, qualifies lock, holds the SoC in
// reset until the clock is stable, and re-sequences on lock loss or core request.
module soc_rst_seq
  import soc_rst_seq_pkg::*;
#(
  parameter int PLL_RST_CYC      = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 500000,
  parameter int SOC_HOLD_CYC     = 64,
  parameter int LED_HALF_CYC     = 50000000,
  parameter int CNT_W            = 32
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       sys_reset_req,
  output logic       pll_rst,
  output logic       soc_rst_n,
  output logic       run,
  output logic [3:0] lock_fail_cnt,
  output logic       led_1s
);

  logic             lock_s, req_s, req_prev_q, req_rise;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] st_cnt_q, st_cnt_d, stab_q, stab_d, tmo_q, tmo_d, led_cnt_q, led_cnt_d;
  logic [3:0]       fail_q, fail_d;
  logic             fail_inc, led_q, led_d;
  logic             pll_rst_q, soc_rst_n_q, run_q;

  sync_2ff u_sync_lock (.clk_i(sysclk), .rst_ni(rst_n), .d_i(pll_lock),      .q_o(lock_s));
  sync_2ff u_sync_req  (.clk_i(sysclk), .rst_ni(rst_n), .d_i(sys_reset_req), .q_o(req_s));

  // Edge detect so a request held high only costs one SOC_HOLD pass.
  assign req_rise = req_s & ~req_prev_q;

  always_comb begin
    state_d  = state_q;
    fail_inc = 1'b0;
    st_cnt_d = '0;
    stab_d   = '0;
    tmo_d    = '0;
    case (state_q)
      ST_PLL_RST: begin
        st_cnt_d = st_cnt_q + 1'b1;
        if (st_cnt_q == CNT_W'(PLL_RST_CYC - 1)) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        stab_d = lock_s ? stab_q + 1'b1 : '0;
        tmo_d  = tmo_q + 1'b1;
        // Qualification beats a timeout landing on the same cycle.
        if (lock_s && stab_q == CNT_W'(LOCK_STABLE_CYC - 1)) begin
          state_d = ST_SOC_HOLD;
        end else if (tmo_q == CNT_W'(LOCK_TIMEOUT_CYC - 1)) begin
          state_d  = ST_PLL_RST;
          fail_inc = 1'b1;
        end
      end
      ST_SOC_HOLD: begin
        st_cnt_d = st_cnt_q + 1'b1;
        if (!lock_s) begin
          state_d  = ST_PLL_RST;
          fail_inc = 1'b1;
        end else if (st_cnt_q == CNT_W'(SOC_HOLD_CYC - 1)) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        if (!lock_s) begin
          state_d  = ST_PLL_RST;
          fail_inc = 1'b1;
        end else if (req_rise) begin
          state_d = ST_SOC_HOLD;
        end
      end
    endcase
    if (state_d != state_q) begin
      st_cnt_d = '0;
      stab_d   = '0;
      tmo_d    = '0;
    end
  end

  // Heartbeat only advances while RUN persists; any exit forces it dark.
  always_comb begin
    led_cnt_d = '0;
    led_d     = 1'b0;
    if (state_d == ST_RUN && state_q == ST_RUN) begin
      if (led_cnt_q == CNT_W'(LED_HALF_CYC - 1)) begin
        led_cnt_d = '0;
        led_d     = ~led_q;
      end else begin
        led_cnt_d = led_cnt_q + 1'b1;
        led_d     = led_q;
      end
    end
  end

  assign fail_d = fail_inc ? sat_inc4(fail_q) : fail_q;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PLL_RST;
      st_cnt_q    <= '0;
      stab_q      <= '0;
      tmo_q       <= '0;
      led_cnt_q   <= '0;
      led_q       <= 1'b0;
      fail_q      <= '0;
      req_prev_q  <= 1'b0;
      pll_rst_q   <= 1'b1;
      soc_rst_n_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_cnt_q    <= st_cnt_d;
      stab_q      <= stab_d;
      tmo_q       <= tmo_d;
      led_cnt_q   <= led_cnt_d;
      led_q       <= led_d;
      fail_q      <= fail_d;
      req_prev_q  <= req_s;
      pll_rst_q   <= (state_d == ST_PLL_RST);
      soc_rst_n_q <= (state_d == ST_RUN);
      run_q       <= (state_d == ST_RUN);
    end
  end

  assign pll_rst       = pll_rst_q;
  assign soc_rst_n     = soc_rst_n_q;
  assign run           = run_q;
  assign lock_fail_cnt = fail_q;
  assign led_1s        = led_q;

endmodule

// File: tb/tb_soc_rst_seq.sv
// Directed bench for soc_rst_seq with shortened timing parameters.
module tb_soc_rst_seq;

  logic       sysclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       sys_reset_req = 1'b0;
  logic       pll_rst, soc_rst_n, run, led_1s;
  logic [3:0] lock_fail_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int e = 0;

  soc_rst_seq #(
    .PLL_RST_CYC(4), .LOCK_STABLE_CYC(8), .LOCK_TIMEOUT_CYC(32),
    .SOC_HOLD_CYC(6), .LED_HALF_CYC(10), .CNT_W(32)
  ) dut (
    .sysclk(sysclk), .rst_n(rst_n), .pll_lock(pll_lock), .sys_reset_req(sys_reset_req),
    .pll_rst(pll_rst), .soc_rst_n(soc_rst_n), .run(run),
    .lock_fail_cnt(lock_fail_cnt), .led_1s(led_1s)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, e, obs, exp);
    end
  endtask

  // Advance to edge number 'target' after rst_n release, then settle 1 time unit.
  task automatic step_to(input int target);
    while (e < target) begin
      @(posedge sysclk);
      e++;
    end
    #1;
  endtask

  task automatic do_reset(input logic lock);
    rst_n = 1'b0;
    pll_lock = lock;
    sys_reset_req = 1'b0;
    @(posedge sysclk);
    #1;
    rst_n = 1'b1;
    e = 0;
  endtask

  int soc_low, pll_hi, soc_hi;

  initial begin
    // ---------- Normal boot, LED, request, lock loss, async reset ----------
    do_reset(1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_soc_rst_n", soc_rst_n, 0);
    chk("rst_run", run, 0);
    chk("rst_fail_cnt", lock_fail_cnt, 0);
    chk("rst_led", led_1s, 0);
    rst_n = 1'b1;
    e = 0;

    step_to(3);  chk("boot_pll_rst_e3", pll_rst, 1);
    step_to(4);  chk("boot_pll_rst_e4", pll_rst, 0);
    step_to(17); chk("boot_soc_e17", soc_rst_n, 0);
    step_to(18); chk("boot_soc_e18", soc_rst_n, 1);
    chk("boot_run_e18", run, 1);
    chk("boot_cnt_e18", lock_fail_cnt, 0);
    chk("boot_pll_rst_e18", pll_rst, 0);

    step_to(27); chk("led_e27", led_1s, 0);
    step_to(28); chk("led_e28", led_1s, 1);
    step_to(37); chk("led_e37", led_1s, 1);
    step_to(38); chk("led_e38", led_1s, 0);

    // Request held high for 50 cycles: exactly one 6-cycle SoC reset pulse.
    step_to(40); sys_reset_req = 1'b1;
    step_to(42); chk("req_soc_e42", soc_rst_n, 1);
    step_to(43); chk("req_soc_e43", soc_rst_n, 0);
    chk("req_run_e43", run, 0);
    soc_low = 1; pll_hi = 0;
    while (e < 90) begin
      step_to(e + 1);
      if (!soc_rst_n) soc_low++;
      if (pll_rst) pll_hi++;
      if (e == 48) chk("req_soc_e48", soc_rst_n, 0);
      if (e == 49) chk("req_run_e49", run, 1);
    end
    chk("req_low_cycles", soc_low, 6);
    chk("req_pll_rst_hi", pll_hi, 0);
    sys_reset_req = 1'b0;

    // Lock drop in RUN while LED is lit (RUN since 49, LED on from 99).
    step_to(100); pll_lock = 1'b0;
    step_to(102); chk("drop_run_e102", run, 1);
    chk("drop_led_e102", led_1s, 1);
    step_to(103); chk("drop_pll_rst", pll_rst, 1);
    chk("drop_soc", soc_rst_n, 0);
    chk("drop_run", run, 0);
    chk("drop_led", led_1s, 0);
    chk("drop_cnt", lock_fail_cnt, 1);
    pll_lock = 1'b1;
    step_to(120); chk("relock_soc_e120", soc_rst_n, 0);
    step_to(121); chk("relock_soc_e121", soc_rst_n, 1);

    // Lock loss and request edge on the same cycle: lock loss wins.
    step_to(125); pll_lock = 1'b0; sys_reset_req = 1'b1;
    step_to(127); chk("both_run_e127", run, 1);
    step_to(128); chk("both_pll_rst", pll_rst, 1);
    chk("both_cnt", lock_fail_cnt, 2);
    pll_lock = 1'b1; sys_reset_req = 1'b0;
    step_to(146); chk("both_rerun", run, 1);

    // Async reset mid-RUN while LED lit.
    step_to(157); chk("arst_led_before", led_1s, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pll_rst", pll_rst, 1);
    chk("arst_soc", soc_rst_n, 0);
    chk("arst_run", run, 0);
    chk("arst_cnt", lock_fail_cnt, 0);
    chk("arst_led", led_1s, 0);

    // ---------- Lock never arrives ----------
    do_reset(1'b0);
    step_to(35); chk("nolock_pll_e35", pll_rst, 0);
    chk("nolock_cnt_e35", lock_fail_cnt, 0);
    step_to(36); chk("nolock_pll_e36", pll_rst, 1);
    chk("nolock_cnt_e36", lock_fail_cnt, 1);
    step_to(39); chk("nolock_pll_e39", pll_rst, 1);
    step_to(40); chk("nolock_pll_e40", pll_rst, 0);
    step_to(72); chk("nolock_cnt_e72", lock_fail_cnt, 2);
    step_to(539); chk("nolock_cnt_e539", lock_fail_cnt, 14);
    step_to(540); chk("nolock_cnt_e540", lock_fail_cnt, 15);
    soc_hi = 0;
    while (e < 620) begin
      step_to(e + 1);
      if (soc_rst_n || run) soc_hi++;
    end
    chk("nolock_cnt_sat", lock_fail_cnt, 15);
    chk("nolock_soc_hi", soc_hi, 0);

    // ---------- Lock glitch at stable count 5 ----------
    do_reset(1'b1);
    step_to(7); pll_lock = 1'b0;
    step_to(8); pll_lock = 1'b1;
    step_to(18); chk("glitch_soc_e18", soc_rst_n, 0);
    step_to(23); chk("glitch_soc_e23", soc_rst_n, 0);
    step_to(24); chk("glitch_soc_e24", soc_rst_n, 1);
    chk("glitch_cnt", lock_fail_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
